// File: rtl/mdu_pkg.sv
// Shared types, op codes and state encodings for the multiply/divide unit.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 4;

  typedef logic [OP_W-1:0] mdu_op_t;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } mdu_hilo_t;

  localparam mdu_op_t MDU_OP_NOP   = 4'd0;
  localparam mdu_op_t MDU_OP_MULT  = 4'd1;
  localparam mdu_op_t MDU_OP_MULTU = 4'd2;
  localparam mdu_op_t MDU_OP_DIV   = 4'd3;
  localparam mdu_op_t MDU_OP_DIVU  = 4'd4;
  localparam mdu_op_t MDU_OP_MTHI  = 4'd5;
  localparam mdu_op_t MDU_OP_MTLO  = 4'd6;
  localparam mdu_op_t MDU_OP_MADD  = 4'd7;
  localparam mdu_op_t MDU_OP_MADDU = 4'd8;
  localparam mdu_op_t MDU_OP_MSUB  = 4'd9;
  localparam mdu_op_t MDU_OP_MSUBU = 4'd10;

  localparam logic [1:0] MDU_ST_IDLE = 2'd0;
  localparam logic [1:0] MDU_ST_MUL  = 2'd1;
  localparam logic [1:0] MDU_ST_DIV  = 2'd2;

  // Accumulate ops only count as mult-class when the feature is built in.
  function automatic logic is_mult_op(input mdu_op_t op);
    case (op)
      MDU_OP_MULT, MDU_OP_MULTU: is_mult_op = 1'b1;
`ifdef MDU_MADD_EN
      MDU_OP_MADD, MDU_OP_MADDU,
      MDU_OP_MSUB, MDU_OP_MSUBU: is_mult_op = 1'b1;
`endif
      default:                   is_mult_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input mdu_op_t op);
    is_div_op = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface mdu_if;
  import mdu_pkg::*;

  logic            mdu_i_Start;
  mdu_op_t         mdu_i_Op;
  logic [XLEN-1:0] mdu_i_A;
  logic [XLEN-1:0] mdu_i_B;
  logic            mdu_o_Busy;
  logic [XLEN-1:0] mdu_o_Hi;
  logic [XLEN-1:0] mdu_o_Lo;

  modport master (
    output mdu_i_Start, mdu_i_Op, mdu_i_A, mdu_i_B,
    input  mdu_o_Busy, mdu_o_Hi, mdu_o_Lo
  );

  modport slave (
    input  mdu_i_Start, mdu_i_Op, mdu_i_A, mdu_i_B,
    output mdu_o_Busy, mdu_o_Hi, mdu_o_Lo
  );
endinterface

// File: rtl/mdu_calc.sv
// Combinational arithmetic: op, operands and current HI/LO -> 64-bit pending result.
// MDU_MADD_EN adds the multiply-accumulate/subtract variants.
module mdu_calc
  import mdu_pkg::*;
(
  input  mdu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output mdu_hilo_t       res_c
);

  logic [2*XLEN-1:0] prod_s, prod_u, hilo;
  logic              a_neg, b_neg, div_ok;
  logic [XLEN-1:0]   a_mag, b_mag, b_mag_safe, b_safe;
  logic [XLEN-1:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;

  always_comb begin
    hilo   = {hi, lo};
    prod_s = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
    prod_u = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps instead of trapping.
    div_ok     = (b != '0);
    a_neg      = a[XLEN-1];
    b_neg      = b[XLEN-1];
    a_mag      = a_neg ? (~a + XLEN'(1)) : a;
    b_mag      = b_neg ? (~b + XLEN'(1)) : b;
    b_mag_safe = div_ok ? b_mag : XLEN'(1);
    b_safe     = div_ok ? b : XLEN'(1);
    q_mag      = a_mag / b_mag_safe;
    r_mag      = a_mag % b_mag_safe;
    q_s        = (a_neg ^ b_neg) ? (~q_mag + XLEN'(1)) : q_mag;
    r_s        = a_neg ? (~r_mag + XLEN'(1)) : r_mag;
    q_u        = a / b_safe;
    r_u        = a % b_safe;

    res_c = hilo;
    case (op)
      MDU_OP_MULT:  res_c = prod_s;
      MDU_OP_MULTU: res_c = prod_u;
      MDU_OP_DIV:   if (div_ok) res_c = {r_s, q_s};
      MDU_OP_DIVU:  if (div_ok) res_c = {r_u, q_u};
`ifdef MDU_MADD_EN
      MDU_OP_MADD:  res_c = hilo + prod_s;
      MDU_OP_MADDU: res_c = hilo + prod_u;
      MDU_OP_MSUB:  res_c = hilo - prod_s;
      MDU_OP_MSUBU: res_c = hilo - prod_u;
`endif
      default:      res_c = hilo;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: sole HI/LO writer, fixed-latency busy window then commit.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (mult-class latency).
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input logic  mdu_i_clk,
  input logic  mdu_i_rst_n,
  mdu_if.slave bus
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MULT_INIT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  mdu_hilo_t        pend_q, pend_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
  mdu_hilo_t        calc_c;

  mdu_calc u_calc (
    .op    (bus.mdu_i_Op),
    .a     (bus.mdu_i_A),
    .b     (bus.mdu_i_B),
    .hi    (hi_q),
    .lo    (lo_q),
    .res_c (calc_c)
  );

  always_ff @(posedge mdu_i_clk or negedge mdu_i_rst_n) begin
    if (!mdu_i_rst_n) begin
      state_q <= MDU_ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Starts are only honoured in IDLE; anything issued while busy is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MDU_ST_IDLE: begin
        if (bus.mdu_i_Start) begin
          if (is_mult_op(bus.mdu_i_Op)) begin
            pend_d  = calc_c;
            state_d = MDU_ST_MUL;
            cnt_d   = MULT_INIT;
            busy_d  = 1'b1;
          end else if (is_div_op(bus.mdu_i_Op)) begin
            pend_d  = calc_c;
            state_d = MDU_ST_DIV;
            cnt_d   = DIV_INIT;
            busy_d  = 1'b1;
          end else if (bus.mdu_i_Op == MDU_OP_MTHI) begin
            hi_d = bus.mdu_i_A;
          end else if (bus.mdu_i_Op == MDU_OP_MTLO) begin
            lo_d = bus.mdu_i_A;
          end
        end
      end
      MDU_ST_MUL, MDU_ST_DIV: begin
        if (cnt_q == '0) begin
          hi_d    = pend_q.hi;
          lo_d    = pend_q.lo;
          busy_d  = 1'b0;
          state_d = MDU_ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MDU_ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.mdu_o_Busy = busy_q;
  assign bus.mdu_o_Hi   = hi_q;
  assign bus.mdu_o_Lo   = lo_q;

endmodule
